// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the FND scan display back end.
//   conv_state_e : states of the sequential binary-to-BCD converter
//   SEG_0..SEG_9 : active-low segment codes {dp,g,f,e,d,c,b,a}, dp off
//   SEG_BLANK    : all segments off
//   NUM_DIGITS   : digits on the display
//   SHIFT_COUNT  : shifts needed to convert a 9-bit value
//   seg_encode() : BCD nibble to segment code (non-decimal -> blank)
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int NUM_DIGITS  = 4;
    localparam int SHIFT_COUNT = 9;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 converter, 9-bit binary to 3 BCD digits.
//   clk, reset : clock, asynchronous active-high reset
//   bin        : binary value, captured when start is seen in IDLE
//   start      : begin a conversion (only honoured in IDLE)
//   done       : high for the single DONE cycle; bcd is valid then
//   bcd        : {hundreds, tens, ones}
//   state      : current converter state, for observation
// Handshake: start is a request accepted only while state == ST_IDLE; the
// result is presented for exactly one cycle with done high and no stall.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  bin,
    input  logic        start,
    output logic        done,
    output logic [11:0] bcd,
    output conv_state_e state
);

    conv_state_e state_q, state_d;
    logic [8:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] adj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        // Nibbles >= 5 would overflow past 9 on the next doubling; pre-add 3.
        adj     = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(SHIFT_COUNT - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bcd   = bcd_q;
    assign state = state_q;

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: converts the 9-bit adder result to BCD and scans it onto a
// 4-digit common-anode 7-segment display.
//   SCAN_DIV : cycles each digit stays enabled (>= 2)
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   sum      : {carry, sum[7:0]}, 0..510
//   fnd_data : active-low segments {dp,g,f,e,d,c,b,a}
//   fnd_com  : active-low one-hot digit enable, bit0 = ones
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (thousands always blank); otherwise all four digits show with zeros.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] sum,
    output logic [7:0] fnd_data,
    output logic [3:0] fnd_com
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [8:0]    src_q, src_d;
    logic [11:0]   disp_q, disp_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic          start;
    logic          conv_done;
    logic [11:0]   conv_bcd;
    conv_state_e   conv_state;
    logic [3:0]    digit;

    // A change is only taken while the converter is idle, so the value in
    // flight always completes and a newer sum is picked up afterwards.
    assign start = (sum != src_q) && (conv_state == ST_IDLE);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (sum),
        .start (start),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .state (conv_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            disp_q <= '0;
            pre_q  <= '0;
            idx_q  <= '0;
            com_q  <= 4'b1110;
            data_q <= SEG_0;
        end else begin
            src_q  <= src_d;
            disp_q <= disp_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        src_d  = start ? sum : src_q;
        // All three digits commit together so the display never mixes values.
        disp_d = conv_done ? conv_bcd : disp_q;

        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end

        case (idx_q)
            2'd0:    digit = disp_q[3:0];
            2'd1:    digit = disp_q[7:4];
            2'd2:    digit = disp_q[11:8];
            default: digit = 4'd0;
        endcase

        data_d = seg_encode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    if (disp_q[11:4] == 8'd0) data_d = SEG_BLANK;
            2'd2:    if (disp_q[11:8] == 4'd0) data_d = SEG_BLANK;
            2'd3:    data_d = SEG_BLANK;
            default: ;
        endcase
`endif
        com_d = ~(4'b0001 << idx_q);
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] sum;
    logic [7:0] fnd_data;
    logic [3:0] fnd_com;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .sum      (sum),
        .fnd_data (fnd_data),
        .fnd_com  (fnd_com)
    );

    // ---------------- reference model ----------------
    // Conversion is modelled only by its observable timing: a value seen
    // different from the last captured one while idle becomes visible in the
    // display registers 10 edges later; digits come from decimal arithmetic.
    int         m_src, m_busy, m_disp, m_pre, m_idx;
    logic [3:0] m_com;
    logic [7:0] m_data;

    function automatic logic [7:0] seg_of(int d);
        logic [7:0] t [10];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    function automatic logic [7:0] model_code(int v, int pos);
        int d;
        if (pos == 0)      d = v % 10;
        else if (pos == 1) d = (v / 10) % 10;
        else if (pos == 2) d = (v / 100) % 10;
        else               d = 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 3 || (pos == 2 && v < 100) || (pos == 1 && v < 10)) return 8'hFF;
`endif
        return seg_of(d);
    endfunction

    task automatic model_reset();
        m_src = 0; m_busy = 0; m_disp = 0; m_pre = 0; m_idx = 0;
        m_com = 4'b1110; m_data = 8'hC0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        m_com  = ~(4'b0001 << m_idx);
        m_data = model_code(m_disp, m_idx);
        if (m_busy == 0) begin
            if (int'(sum) != m_src) begin
                m_src  = int'(sum);
                m_busy = 10;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) m_disp = m_src;
        end
        m_pre++;
        if (m_pre == SCAN_DIV) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 4;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] prev_com;
    int         run_len;
    bit         hold_chk;
    bit         run_valid;
    int         wraps;

    function automatic int com_pos(logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("fnd_com", int'(fnd_com), int'(m_com));
        check("fnd_data", int'(fnd_data), int'(m_data));
        check("onehot_low", $countones(fnd_com), 3);
        if (fnd_com == prev_com) begin
            run_len++;
        end else begin
            if (hold_chk && run_valid) check("hold_len", run_len, SCAN_DIV);
            if (hold_chk) run_valid = 1'b1;
            if (prev_com == 4'b0111 && fnd_com == 4'b1110) wraps++;
            run_len = 1;
        end
        prev_com = fnd_com;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Collect one full scan: segment code seen for each digit position.
    task automatic scan(output logic [7:0] obs [4]);
        for (int i = 0; i < 4; i++) obs[i] = 8'h00;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            step();
            obs[com_pos(fnd_com)] = fnd_data;
        end
    endtask

    typedef struct {
        int          s;
        logic [31:0] exp_off; // {thousands, hundreds, tens, ones}
        logic [31:0] exp_on;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] obs [4];
    logic [31:0] e;

    initial begin
        tbl[0] = '{510, 32'hC0_92_F9_C0, 32'hFF_92_F9_C0};
        tbl[1] = '{7,   32'hC0_C0_C0_F8, 32'hFF_FF_FF_F8};
        tbl[2] = '{45,  32'hC0_C0_99_92, 32'hFF_FF_99_92};
        tbl[3] = '{100, 32'hC0_F9_C0_C0, 32'hFF_F9_C0_C0};
        tbl[4] = '{9,   32'hC0_C0_C0_90, 32'hFF_FF_FF_90};
        tbl[5] = '{123, 32'hC0_F9_A4_B0, 32'hFF_F9_A4_B0};
        tbl[6] = '{86,  32'hC0_C0_80_82, 32'hFF_FF_80_82};
        tbl[7] = '{0,   32'hC0_C0_C0_C0, 32'hFF_FF_FF_C0};
        tbl[8] = '{250, 32'hC0_A4_92_C0, 32'hFF_A4_92_C0};

        hold_chk = 1'b0; run_valid = 1'b0; run_len = 0; wraps = 0;
        prev_com = 4'b1110;
        reset = 1'b1;
        sum   = 9'd0;
        model_reset();

        // Reset with sum = 0.
        @(negedge clk);
        check("rst_com", int'(fnd_com), 4'b1110);
        check("rst_data", int'(fnd_data), 8'hC0);
        steps(2);
        reset = 1'b0;
        steps(3 * SCAN_DIV);

        // Table of values with full-scan digit checks.
        for (int v = 0; v < 9; v++) begin
            sum = 9'(tbl[v].s);
            steps(12);
            scan(obs);
`ifdef LEADING_ZERO_BLANK_EN
            e = tbl[v].exp_on;
`else
            e = tbl[v].exp_off;
`endif
            for (int p = 0; p < 4; p++) check($sformatf("tbl%0d_pos%0d", v, p), int'(obs[p]), int'(e[p*8 +: 8]));
        end

        // 123 then 45 three cycles after capture.
        sum = 9'd123;
        step();                  // capture edge k
        steps(3);
        sum = 9'd45;
        steps(30);
        scan(obs);
        for (int p = 0; p < 4; p++) check($sformatf("chg45_pos%0d", p), int'(obs[p]), int'(model_code(45, p)));

        // Reset pulse in the middle of a conversion of 300.
        sum = 9'd300;
        step();
        steps(4);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_com", int'(fnd_com), 4'b1110);
        check("midrst_data", int'(fnd_data), 8'hC0);
        @(negedge clk);
        step();
        reset = 1'b0;
        steps(12);
        scan(obs);
        for (int p = 0; p < 4; p++) check($sformatf("v300_pos%0d", p), int'(obs[p]), int'(model_code(300, p)));

        // Free run: hold lengths and index wraps.
        hold_chk = 1'b1; run_valid = 1'b0; wraps = 0;
        steps(8 * SCAN_DIV);
        check("wraps", wraps, 2);
        hold_chk = 1'b0;

        // Randomized values and hold times against the model.
        for (int r = 0; r < 40; r++) begin
            sum = 9'($urandom_range(0, 510));
            steps($urandom_range(1, 20));
        end
        steps(12 + 4 * SCAN_DIV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Sequential display back end for the calculator datapath: consumes the 9-bit adder result (carry concatenated above the 8-bit sum, range 0–510), converts it to BCD with an iterative shift-add-3 engine, and time-multiplexes the digits onto a 4-digit common-anode 7-segment display. It sits directly downstream of the 8-bit adder and drives the board FND pins.

## Interface
- SCAN_DIV, 100_000, clock cycles each digit stays enabled; must be ≥ 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- sum  in  9  unsigned binary value to display, {carry, sum[7:0]}.
- fnd_data  out  8  segment drive, active-low; bit7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- fnd_com  out  4  digit enables, active-low, one-hot-low; bit0 = ones digit, bit3 = thousands digit.

## Operation
- The block has one clock, and reset is asynchronous and active-high, as already decided for this block.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if sum != src_reg, capture sum into src_reg and the shift register, clear BCD accumulator, go to SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1; after exactly 9 shifts go to DONE.
  - DONE: copy ones/tens/hundreds nibbles to display registers in one cycle (atomic, no partial update); go to IDLE.
- sum changing during SHIFT/DONE is ignored until IDLE; the captured value always completes, then the newer value converts next. Display never shows mixed digits from two values.
- Thousands digit value is always 0 (max 510).
- Scan: prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit index (2 bits) increments, 3 wraps to 0.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF; dp always off.
- fnd_com = ~(4'b0001 << index); fnd_data = code of the indexed digit.

## Timing
- Reset values: state IDLE, src_reg 0, display digits 0, prescaler 0, index 0, fnd_com 4'b1110, fnd_data 8'hC0.
- fnd_com and fnd_data are registered, updating one cycle after index or display registers change.
- Conversion latency: capture at edge k; shifts on edges k+1..k+9; display regs commit at edge k+10; outputs reflect it at edge k+11.
- A new sum can be accepted at the IDLE edge immediately following DONE, giving a minimum period of 11 cycles.
- Each digit is enabled for SCAN_DIV cycles; full refresh takes 4×SCAN_DIV cycles. Exactly one fnd_com bit is low at all times after reset.
- Reset asserted mid-conversion aborts immediately to reset values. After release, the first edge compares sum with src_reg = 0 and starts a conversion if sum is nonzero.

## Configuration
- LEADING_ZERO_BLANK_EN defined: thousands digit is always FF. Hundreds is FF when it is 0. Tens is FF when hundreds and tens are both 0. Ones is always shown.
- LEADING_ZERO_BLANK_EN undefined: all four digits are shown with leading zeros (display range 0000–0510).
- Blanking is decided from the committed display registers, so it changes only at the DONE commit.

## Structure
- Package fnd_pkg holds:
  - converter state enum (IDLE/SHIFT/DONE);
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - NUM_DIGITS = 4;
  - SHIFT_COUNT = 9.
- Sub-module bin2bcd_seq contains the converter FSM with ports clk, reset, bin[8:0], start, done, bcd[11:0].
- The top level holds the change detect, display registers, prescaler, index, and output decode.

## Test plan
- Reset with sum=0 and SCAN_DIV=4 -> fnd_com=1110 and fnd_data=C0 during reset. No conversion starts, and the display stays 0000.
- sum=510, SCAN_DIV=4, macro off -> 11 cycles after capture, one full scan gives (1110,C0), (1101,F9), (1011,92), (0111,C0).
- Same stimulus with LEADING_ZERO_BLANK_EN defined -> scan gives C0, F9, 92, FF. With sum=7 the scan gives F8, FF, FF, FF.
- sum=123, then change to 45 three cycles after capture -> display commits 123 at k+10. The second capture happens at k+11, and 045 is committed at k+21. No mixed digits are ever seen.
- Reset pulse during SHIFT while sum=300 -> outputs return to 1110/C0 immediately. After release, 300 is converted and shown within 12 cycles.
- Free-run 8×SCAN_DIV cycles -> index wraps 3→0 twice. Each fnd_com pattern is held exactly SCAN_DIV cycles, and exactly one bit is low throughout.
